btn_input_ctrl: RTL and testbench

Sequencer between the button debouncer and the processor's input instruction path. It waits for a processor input request, then requires a clean press-and-release of the debounced "enter" button. It captures the switch word on the press edge and returns it with a one-cycle valid pulse, stalling the processor in the meantime. A long press discards the captured word and re-arms the capture.

---
 rtl/btn_input_ctrl.sv | 61 ++++++
 tb/tb_btn_input_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/btn_input_ctrl.sv
// btn_input_ctrl: waits for an input request, captures sw on a clean button press, returns it on release.
module btn_input_ctrl #(
  parameter int DATA_W     = 16,
  parameter int CNT_W      = 25,
  parameter int LONG_PRESS = 19_000_000
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              db_btn,
  input  logic [DATA_W-1:0] sw,
  input  logic              in_req,
  output logic [DATA_W-1:0] in_data,
  output logic              in_valid,
  output logic              in_busy,
  output logic              long_press,
  output logic [2:0]        state_dbg
);
  localparam logic [CNT_W-1:0] LP = CNT_W'(LONG_PRESS);
  typedef enum logic [2:0] {IDLE, ARM, WAIT_PRESS, PRESSED, ACK} state_t;
  state_t state, state_nx;
  logic btn_q, rise, capture, cnt_inc;
  logic [CNT_W-1:0] cnt;
  assign rise = db_btn & ~btn_q;
  always_comb begin
    state_nx = state;
    capture = 1'b0;
    cnt_inc = 1'b0;
    case (state)
      IDLE:       state_nx = !in_req ? IDLE : db_btn ? ARM : WAIT_PRESS;
      ARM:        state_nx = !in_req ? IDLE : db_btn ? ARM : WAIT_PRESS;
      WAIT_PRESS: begin
        state_nx = !in_req ? IDLE : rise ? PRESSED : WAIT_PRESS;
        capture = in_req && rise;
      end
      PRESSED:    begin
        state_nx = !in_req ? IDLE : db_btn ? PRESSED : cnt == LP ? WAIT_PRESS : ACK;
        cnt_inc = in_req && db_btn && cnt != LP;
      end
      default:    state_nx = IDLE;
    endcase
  end
  // long_press fires on the increment that lands the counter on LP, so it is a single pulse
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state <= IDLE;
      btn_q <= 1'b0;
      cnt <= '0;
      in_data <= '0;
      long_press <= 1'b0;
    end else begin
      state <= state_nx;
      btn_q <= db_btn;
      cnt <= capture ? '0 : cnt_inc ? cnt + 1'b1 : cnt;
      in_data <= capture ? sw : in_data;
      long_press <= cnt_inc && cnt == LP - 1'b1;
    end
  end
  assign in_valid = state == ACK;
  assign in_busy = state == ARM || state == WAIT_PRESS || state == PRESSED;
  assign state_dbg = state;
endmodule

// File: tb/tb_btn_input_ctrl.sv
// tb_btn_input_ctrl: directed scenarios plus random traffic against a behavioural model of the sequencer.
module tb_btn_input_ctrl;
  localparam int LP = 8;
  logic clk = 1'b0, n_reset = 1'b0, db_btn = 1'b0, in_req = 1'b0;
  logic [15:0] sw = '0, in_data;
  logic in_valid, in_busy, long_press;
  logic [2:0] state_dbg;
  int vectors = 0, errs = 0;

  btn_input_ctrl #(.DATA_W(16), .CNT_W(25), .LONG_PRESS(LP)) dut (
    .clk(clk), .n_reset(n_reset), .db_btn(db_btn), .sw(sw), .in_req(in_req),
    .in_data(in_data), .in_valid(in_valid), .in_busy(in_busy),
    .long_press(long_press), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // model: phase 0 idle, 1 waiting for release of a stale press, 2 waiting for press, 3 held, 4 handing back
  int m_phase = 0, m_held = 0;
  logic [15:0] m_data = '0;
  logic m_prev = 1'b0, m_lp = 1'b0;

  task automatic model_step();
    logic pressed_now;
    pressed_now = db_btn && !m_prev;
    m_lp = 1'b0;
    if (!n_reset) begin
      m_phase = 0; m_held = 0; m_data = '0; m_prev = 1'b0;
      return;
    end
    if (m_phase == 4) m_phase = 0;
    else if (m_phase != 0 && !in_req) m_phase = 0;
    else if (m_phase == 0) m_phase = in_req ? (db_btn ? 1 : 2) : 0;
    else if (m_phase == 1) m_phase = db_btn ? 1 : 2;
    else if (m_phase == 2) begin
      if (pressed_now) begin m_data = sw; m_held = 0; m_phase = 3; end
    end else if (db_btn) begin
      if (m_held < LP) begin m_held++; m_lp = (m_held == LP); end
    end else m_phase = (m_held == LP) ? 2 : 4;
    m_prev = db_btn;
  endtask

  task automatic tick(input logic r, input logic b, input logic [15:0] s);
    in_req = r; db_btn = b; sw = s;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    n_reset = 1'b0;
    tick(1'b1, 1'b1, 16'hFFFF);
    tick(1'b1, 1'b1, 16'hFFFF);
    vectors++; if (in_data !== 16'h0) begin errs++; $display("FAIL reset_data got %h want 0000", in_data); end
    vectors++; if ({in_valid, in_busy, long_press} !== 3'b000) begin errs++; $display("FAIL reset_flags got %b want 000", {in_valid, in_busy, long_press}); end
    vectors++; if (state_dbg !== 3'd0) begin errs++; $display("FAIL reset_state got %0d want 0", state_dbg); end
    n_reset = 1'b1;
    tick(1'b0, 1'b0, 16'h0);
  endtask

  task automatic test_short_press();
    tick(1'b1, 1'b0, 16'h1111);
    vectors++; if (in_busy !== 1'b1 || state_dbg !== 3'd2) begin errs++; $display("FAIL short_req busy=%b state=%0d want 1/2", in_busy, state_dbg); end
    tick(1'b1, 1'b1, 16'hA5C3);
    vectors++; if (in_data !== 16'hA5C3 || state_dbg !== 3'd3) begin errs++; $display("FAIL short_capture data=%h state=%0d want a5c3/3", in_data, state_dbg); end
    tick(1'b1, 1'b1, 16'h0BAD);
    tick(1'b1, 1'b1, 16'h0BAD);
    vectors++; if (in_busy !== 1'b1 || in_valid !== 1'b0 || in_data !== 16'hA5C3) begin errs++; $display("FAIL short_held busy=%b valid=%b data=%h want 1/0/a5c3", in_busy, in_valid, in_data); end
    tick(1'b1, 1'b0, 16'h0BAD);
    vectors++; if (in_valid !== 1'b1 || in_busy !== 1'b0 || state_dbg !== 3'd4) begin errs++; $display("FAIL short_ack valid=%b busy=%b state=%0d want 1/0/4", in_valid, in_busy, state_dbg); end
    tick(1'b0, 1'b0, 16'h0);
    vectors++; if (in_valid !== 1'b0 || state_dbg !== 3'd0 || in_data !== 16'hA5C3) begin errs++; $display("FAIL short_after valid=%b state=%0d data=%h want 0/0/a5c3", in_valid, state_dbg, in_data); end
  endtask

  task automatic test_held_at_request();
    tick(1'b0, 1'b1, 16'h9999);
    vectors++; if (state_dbg !== 3'd0 || in_busy !== 1'b0) begin errs++; $display("FAIL held_idle state=%0d busy=%b want 0/0", state_dbg, in_busy); end
    tick(1'b1, 1'b1, 16'h9999);
    tick(1'b1, 1'b1, 16'h9999);
    vectors++; if (state_dbg !== 3'd1 || in_busy !== 1'b1 || in_data !== 16'hA5C3) begin errs++; $display("FAIL held_arm state=%0d busy=%b data=%h want 1/1/a5c3", state_dbg, in_busy, in_data); end
    tick(1'b1, 1'b0, 16'h9999);
    vectors++; if (state_dbg !== 3'd2) begin errs++; $display("FAIL held_release state=%0d want 2", state_dbg); end
    tick(1'b1, 1'b1, 16'h0042);
    tick(1'b1, 1'b0, 16'h0);
    vectors++; if (in_valid !== 1'b1 || in_data !== 16'h0042) begin errs++; $display("FAIL held_result valid=%b data=%h want 1/0042", in_valid, in_data); end
    tick(1'b0, 1'b0, 16'h0);
  endtask

  task automatic test_long_press();
    int pulses = 0;
    tick(1'b1, 1'b0, 16'h0);
    tick(1'b1, 1'b1, 16'h1111);
    for (int i = 1; i <= 9; i++) begin
      tick(1'b1, 1'b1, 16'h5555);
      pulses += int'(long_press);
      vectors++; if (long_press !== (i == LP)) begin errs++; $display("FAIL long_pulse_%0d got %b want %b", i, long_press, i == LP); end
    end
    vectors++; if (pulses != 1) begin errs++; $display("FAIL long_count got %0d want 1", pulses); end
    tick(1'b1, 1'b0, 16'h0);
    vectors++; if (state_dbg !== 3'd2 || in_valid !== 1'b0 || in_data !== 16'h1111) begin errs++; $display("FAIL long_release state=%0d valid=%b data=%h want 2/0/1111", state_dbg, in_valid, in_data); end
    tick(1'b1, 1'b1, 16'h2222);
    tick(1'b1, 1'b1, 16'h0);
    tick(1'b1, 1'b0, 16'h0);
    vectors++; if (in_valid !== 1'b1 || in_data !== 16'h2222) begin errs++; $display("FAIL long_retry valid=%b data=%h want 1/2222", in_valid, in_data); end
    tick(1'b0, 1'b0, 16'h0);
  endtask

  task automatic test_abort();
    int valids = 0;
    tick(1'b1, 1'b0, 16'h0);
    tick(1'b1, 1'b1, 16'hBEEF);
    tick(1'b0, 1'b1, 16'h0);
    vectors++; if (state_dbg !== 3'd0 || in_busy !== 1'b0 || in_valid !== 1'b0) begin errs++; $display("FAIL abort_state state=%0d busy=%b valid=%b want 0/0/0", state_dbg, in_busy, in_valid); end
    tick(1'b0, 1'b0, 16'h0);
    tick(1'b0, 1'b1, 16'h7777);
    valids += int'(in_valid);
    tick(1'b0, 1'b0, 16'h0);
    valids += int'(in_valid);
    vectors++; if (valids != 0 || in_data !== 16'hBEEF) begin errs++; $display("FAIL abort_idle valids=%0d data=%h want 0/beef", valids, in_data); end
    tick(1'b1, 1'b0, 16'h0);
    tick(1'b0, 1'b1, 16'h6666);
    vectors++; if (state_dbg !== 3'd0 || in_data !== 16'hBEEF) begin errs++; $display("FAIL abort_rise state=%0d data=%h want 0/beef", state_dbg, in_data); end
    tick(1'b0, 1'b0, 16'h0);
  endtask

  task automatic test_reset_mid();
    tick(1'b1, 1'b0, 16'h0);
    tick(1'b1, 1'b1, 16'h1234);
    tick(1'b1, 1'b1, 16'h0);
    n_reset = 1'b0;
    tick(1'b1, 1'b1, 16'h0);
    vectors++; if ({in_data, in_valid, in_busy, long_press, state_dbg} !== 22'h0) begin errs++; $display("FAIL reset_mid data=%h valid=%b busy=%b lp=%b state=%0d want all 0", in_data, in_valid, in_busy, long_press, state_dbg); end
    n_reset = 1'b1;
    tick(1'b0, 1'b0, 16'h0);
  endtask

  task automatic test_back_to_back();
    tick(1'b1, 1'b0, 16'h0);
    tick(1'b1, 1'b1, 16'h0003);
    tick(1'b1, 1'b0, 16'h0);
    vectors++; if (in_valid !== 1'b1 || in_data !== 16'h0003) begin errs++; $display("FAIL b2b_first valid=%b data=%h want 1/0003", in_valid, in_data); end
    tick(1'b1, 1'b0, 16'h0);
    vectors++; if (state_dbg !== 3'd0 || in_valid !== 1'b0) begin errs++; $display("FAIL b2b_idle state=%0d valid=%b want 0/0", state_dbg, in_valid); end
    tick(1'b1, 1'b0, 16'h0);
    vectors++; if (state_dbg !== 3'd2 || in_busy !== 1'b1) begin errs++; $display("FAIL b2b_rearm state=%0d busy=%b want 2/1", state_dbg, in_busy); end
    tick(1'b1, 1'b1, 16'h0004);
    tick(1'b1, 1'b0, 16'h0);
    vectors++; if (in_valid !== 1'b1 || in_data !== 16'h0004) begin errs++; $display("FAIL b2b_second valid=%b data=%h want 1/0004", in_valid, in_data); end
    tick(1'b0, 1'b0, 16'h0);
  endtask

  task automatic test_random();
    int run = 0;
    logic b = 1'b0, r = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (run == 0) begin b = ~b; run = $urandom_range(1, 12); end
      run--;
      if ($urandom_range(0, 19) == 0) r = ~r;
      n_reset = ($urandom_range(0, 299) != 0);
      tick(r, b, 16'($urandom));
      vectors++; if (state_dbg !== 3'(m_phase)) begin errs++; $display("FAIL rnd_state cyc %0d got %0d want %0d", c, state_dbg, m_phase); end
      vectors++; if (in_data !== m_data) begin errs++; $display("FAIL rnd_data cyc %0d got %h want %h", c, in_data, m_data); end
      vectors++; if (in_valid !== (m_phase == 4)) begin errs++; $display("FAIL rnd_valid cyc %0d got %b want %b", c, in_valid, m_phase == 4); end
      vectors++; if (in_busy !== (m_phase >= 1 && m_phase <= 3)) begin errs++; $display("FAIL rnd_busy cyc %0d got %b want %b", c, in_busy, m_phase >= 1 && m_phase <= 3); end
      vectors++; if (long_press !== m_lp) begin errs++; $display("FAIL rnd_long_press cyc %0d got %b want %b", c, long_press, m_lp); end
    end
    n_reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_short_press();
    test_held_at_request();
    test_long_press();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
